mc_fetch_unit: RTL and testbench
================================

Name: mc_fetch_unit

Overview:
- Multi-cycle CPU instruction-fetch sequencer. Owns the program counter and issues instruction-memory reads over a req/ack handshake. Latches the returned word into the instruction register.
- Produces the PC and 26-bit jump field consumed by the jump-target logic. Accepts the computed jump/branch target back as a redirect.
- Sits between the control FSM (fetch_en), instruction memory, and execute-stage target computation.

Parameters:
- RESET_PC, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- TIMEOUT, 16: cycles to wait for imem_ack before abort; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  one-cycle request from control FSM to fetch at current pc.
- redirect_valid  in  1  load redirect_pc into pc.
- redirect_pc  in  32  jump/branch target.
- imem_req  out  1  memory read request, registered.
- imem_addr  out  32  read address, registered; stable while imem_req=1.
- imem_ack  in  1  memory has returned data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- pc  out  32  current program counter.
- pc_plus4  out  32  pc+4, combinational, modulo 2^32.
- ir  out  32  instruction register.
- ir_valid  out  1  one-cycle pulse: ir just loaded.
- jaddr  out  26  ir[25:0], combinational.
- busy  out  1  high in WAIT.
- fetch_err  out  1  sticky timeout flag; 0 when feature compiled out.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, ir=0, imem_req=0, imem_addr=0, ir_valid=0, fetch_err=0, state=IDLE, pending redirect cleared.
- States: IDLE, WAIT.
- IDLE with redirect_valid=1:
  - pc <= {redirect_pc[31:2],2'b00}; low bits are forced to 0, never trapped.
  - fetch_en in the same cycle is ignored; redirect has priority and the control FSM must re-issue.
- IDLE with fetch_en=1 and redirect_valid=0:
  - imem_req<=1, imem_addr<=pc, go WAIT.
  - pc is unchanged until the fetch completes.
- WAIT:
  - imem_req stays 1 and imem_addr is held.
  - fetch_en is ignored (busy=1).
  - redirect_valid=1 stores the target in a pending register; the last one wins.
- WAIT with imem_ack=1 (sampled at the edge):
  - ir <= imem_rdata.
  - ir_valid=1 for exactly the next cycle.
  - imem_req<=0.
  - pc <= pending target if a redirect is pending, else pc+4. Pending is cleared.
  - Return to IDLE.
- Ack latency: first ack is possible the cycle after imem_req rises. Minimum fetch is 2 cycles from fetch_en to ir_valid.
- A redirect coinciding with imem_ack applies, and overrides pc+4.
- Wrap: pc=32'hFFFF_FFFC increments to 32'h0000_0000 with no flag.
- imem_ack while in IDLE is ignored; ir is unchanged.
- Reset mid-WAIT: imem_req drops immediately (asynchronously); the outstanding memory response is the memory's concern and is ignored after reset.

Optional Feature:
- Macro MC_FETCH_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles elapse with no imem_ack: abort. imem_req<=0, ir<=32'h0000_0000 (NOP), ir_valid pulses, fetch_err<=1 (sticky until reset).
  - pc advances by the same rule as a normal completion.
- Undefined:
  - No counter; WAIT persists indefinitely.
  - fetch_err is tied to 0.

Test Plan:
- Reset then fetch_en; memory acks 1 cycle later with 32'h0800_0010 -> imem_addr=0, ir=32'h0800_0010, jaddr=26'h000_0010, ir_valid single pulse, pc=4.
- Three back-to-back fetches with ack delays 1,3,5 -> imem_addr 0,4,8 each held stable while waiting; pc ends at 12; busy high only in WAIT.
- redirect_valid with redirect_pc=32'h0040_0023 in IDLE -> pc=32'h0040_0020; a fetch_en asserted in the same cycle produces no imem_req.
- redirect_pc=32'h0000_1000 during WAIT, ack two cycles later -> ir loaded, pc=32'h0000_1000, not old pc+4.
- Redirect to 32'hFFFF_FFFC, fetch, ack -> pc=0. Also: assert rst_n=0 mid-WAIT -> imem_req=0 without waiting for a clock edge, pc=RESET_PC.
- With MC_FETCH_TIMEOUT_EN and TIMEOUT=16: no ack -> after 16 WAIT cycles ir=0, ir_valid pulse, fetch_err=1 and stays 1 through later good fetches.

Source files
------------

// File: rtl/mc_fetch_unit.sv
// mc_fetch_unit: multi-cycle instruction-fetch sequencer.
// Owns the program counter, issues imem reads over a req/ack handshake and
// latches the returned word into the instruction register.
// Optional feature macro: MC_FETCH_TIMEOUT_EN. When it is defined, a fetch
// left without imem_ack for TIMEOUT cycles is aborted. The aborted fetch
// returns a NOP and sets the sticky fetch_err flag.
module mc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [25:0] jaddr,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        ir_valid_q, ir_valid_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    // Redirect targets are word-aligned by clearing the low bits. Misaligned
    // targets are not trapped.
    logic [31:0] redirect_aligned;
    logic [31:0] pc_inc;
    logic        fetch_done;
    logic        abort;

    assign redirect_aligned = redirect_pc & ~32'h0000_0003;
    assign pc_inc           = pc_q + 32'd4;

`ifdef MC_FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_err_q, fetch_err_d;

    // The counter restarts on every fetch. Reaching TIMEOUT-1 on an edge
    // without an ack means TIMEOUT WAIT edges have passed with no response.
    always_comb begin
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q | abort;
        abort       = 1'b0;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            abort = !imem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
        end
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign abort     = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // Next-state logic for the IDLE/WAIT sequencer and its datapath registers.
    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves it
        // unassigned, which would infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        req_d        = req_q;
        addr_d       = addr_q;
        ir_valid_d   = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        fetch_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A redirect takes priority. A simultaneous fetch_en is
                // dropped and the control FSM has to issue it again.
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                end else if (fetch_en) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                fetch_done = imem_ack || abort;
                if (redirect_valid) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redirect_aligned;
                end
                if (fetch_done) begin
                    ir_d         = abort ? 32'h0000_0000 : imem_rdata;
                    ir_valid_d   = 1'b1;
                    req_d        = 1'b0;
                    state_d      = S_IDLE;
                    pend_valid_d = 1'b0;
                    // A redirect arriving with the ack is the newest one, so
                    // it wins over an older pending target.
                    if (redirect_valid) begin
                        pc_d = redirect_aligned;
                    end else if (pend_valid_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. An asynchronous reset drops imem_req
    // immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= 32'h0000_0000;
            req_q        <= 1'b0;
            addr_q       <= 32'h0000_0000;
            ir_valid_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0000_0000;
        end else begin
            // NOTE: use non-blocking assignments for all sequential state so
            // that every register samples its pre-edge value.
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            ir_valid_q   <= ir_valid_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_inc;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign jaddr     = ir_q[25:0];
    assign busy      = (state_q == S_WAIT);

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Testbench for mc_fetch_unit. It applies table vectors, hand-written corner
// sequences and randomized traffic, and checks them against a
// transaction-level model of the PC.
module tb_mc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ir;
    logic        ir_valid;
    logic [25:0] jaddr;
    logic        busy;
    logic        fetch_err;

    mc_fetch_unit #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .jaddr         (jaddr),
        .busy          (busy),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: the architectural PC and the last IR value.
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    typedef struct {
        logic [31:0] rdata;
        int          ack_delay;
        logic        redir_en;
        int          redir_cyc;
        logic [31:0] redir_pc;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch. The ack arrives ack_delay cycles after imem_req
    // rises. An optional redirect is driven in WAIT cycle redir_cyc.
    task automatic do_fetch(input logic [31:0] rdata, input int ack_delay,
                            input logic redir_en, input int redir_cyc,
                            input logic [31:0] rpc, input logic [31:0] exp_addr,
                            input logic [31:0] exp_pc);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("req_rise", {31'b0, imem_req}, 32'd1);
        check("addr_issue", imem_addr, exp_addr);
        check("busy_wait", {31'b0, busy}, 32'd1);
        check("pc_hold", pc, exp_addr);
        for (int k = 1; k <= ack_delay; k++) begin
            if (k == ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = rdata;
            end
            if (redir_en && k == redir_cyc) begin
                redirect_valid = 1'b1;
                redirect_pc    = rpc;
            end
            tick();
            imem_ack       = 1'b0;
            imem_rdata     = $urandom;
            redirect_valid = 1'b0;
            if (k < ack_delay) begin
                check("req_held", {31'b0, imem_req}, 32'd1);
                check("addr_held", imem_addr, exp_addr);
                check("busy_held", {31'b0, busy}, 32'd1);
                check("irv_low_wait", {31'b0, ir_valid}, 32'd0);
            end
        end
        check("irv_pulse", {31'b0, ir_valid}, 32'd1);
        check("ir_load", ir, rdata);
        check("jaddr", {6'b0, jaddr}, {6'b0, rdata[25:0]});
        check("pc_next", pc, exp_pc);
        check("pc_plus4", pc_plus4, exp_pc + 32'd4);
        check("req_drop", {31'b0, imem_req}, 32'd0);
        check("busy_drop", {31'b0, busy}, 32'd0);
        tick();
        check("irv_single", {31'b0, ir_valid}, 32'd0);
        check("ir_stable", ir, rdata);
        m_pc = exp_pc;
        m_ir = rdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, rp, exp_pc;
        int          d, rc, op;
        logic        ren, fe;

        vecs[0] = '{32'h0800_0010, 1, 1'b0, 0, 32'h0, 32'h0000_0000, 32'h0000_0004};
        vecs[1] = '{32'hA000_0001, 3, 1'b0, 0, 32'h0, 32'h0000_0004, 32'h0000_0008};
        vecs[2] = '{32'h1234_5678, 5, 1'b0, 0, 32'h0, 32'h0000_0008, 32'h0000_000C};
        vecs[3] = '{32'h8C00_1234, 3, 1'b1, 1, 32'h0000_1000, 32'h0000_000C, 32'h0000_1000};
        vecs[4] = '{32'h0000_0020, 2, 1'b1, 2, 32'h0000_2006, 32'h0000_1000, 32'h0000_2004};
        vecs[5] = '{32'hFFFF_FFFF, 1, 1'b0, 0, 32'h0, 32'h0000_2004, 32'h0000_2008};

        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        m_pc           = RESET_PC;
        m_ir           = 32'h0;
        #12;
        check("rst_pc", pc, RESET_PC);
        check("rst_ir", ir, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_irv", {31'b0, ir_valid}, 32'd0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_pc4", pc_plus4, RESET_PC + 32'd4);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven fetches.
        for (int i = 0; i < 6; i++) begin
            do_fetch(vecs[i].rdata, vecs[i].ack_delay, vecs[i].redir_en, vecs[i].redir_cyc,
                     vecs[i].redir_pc, vecs[i].exp_addr, vecs[i].exp_pc);
        end

        // IDLE redirect with fetch_en in the same cycle: the redirect wins
        // and no request is issued.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0023;
        fetch_en       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        m_pc           = 32'h0040_0020;
        check("idle_redir_pc", pc, m_pc);
        check("idle_redir_noreq", {31'b0, imem_req}, 32'd0);
        check("idle_redir_nobusy", {31'b0, busy}, 32'd0);
        tick();
        check("idle_redir_noreq2", {31'b0, imem_req}, 32'd0);

        // Two redirects during WAIT: the last one wins.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("lw_addr", imem_addr, m_pc);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        tick();
        redirect_pc = 32'h0000_5006;
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b1;
        imem_rdata     = 32'h0C00_0ABC;
        tick();
        imem_ack = 1'b0;
        m_pc     = 32'h0000_5004;
        m_ir     = 32'h0C00_0ABC;
        check("lw_pc", pc, m_pc);
        check("lw_ir", ir, m_ir);
        check("lw_irv", {31'b0, ir_valid}, 32'd1);

        // Wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4, 32'h0000_0000);
        do_fetch(32'h2000_0001, 1, 1'b0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000);

        // An ack while IDLE is ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check("idle_ack_ir", ir, m_ir);
        check("idle_ack_irv", {31'b0, ir_valid}, 32'd0);
        check("idle_ack_pc", pc, m_pc);
        check("idle_ack_busy", {31'b0, busy}, 32'd0);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            if (op < 3) begin
                d      = int'($urandom_range(1, 6));
                rd     = $urandom;
                ren    = ($urandom_range(0, 2) == 0);
                rc     = int'($urandom_range(1, d));
                rp     = $urandom;
                exp_pc = ren ? (rp & ~32'h3) : m_pc + 32'd4;
                do_fetch(rd, d, ren, rc, rp, m_pc, exp_pc);
            end else begin
                rp             = $urandom;
                fe             = $urandom_range(0, 1) == 1;
                redirect_valid = 1'b1;
                redirect_pc    = rp;
                fetch_en       = fe;
                tick();
                redirect_valid = 1'b0;
                fetch_en       = 1'b0;
                m_pc           = rp & ~32'h3;
                check("rnd_redir_pc", pc, m_pc);
                check("rnd_redir_noreq", {31'b0, imem_req}, 32'd0);
            end
        end

`ifdef MC_FETCH_TIMEOUT_EN
        // No ack: abort after TIMEOUT WAIT cycles with a NOP and a sticky error.
        check("to_err_before", {31'b0, fetch_err}, 32'd0);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            check("to_busy", {31'b0, busy}, 32'd1);
        end
        tick();
        m_pc = m_pc + 32'd4;
        m_ir = 32'h0;
        check("to_irv", {31'b0, ir_valid}, 32'd1);
        check("to_ir", ir, 32'h0);
        check("to_err", {31'b0, fetch_err}, 32'd1);
        check("to_pc", pc, m_pc);
        check("to_req", {31'b0, imem_req}, 32'd0);
        do_fetch(32'h1111_2222, 2, 1'b0, 0, 32'h0, m_pc, m_pc + 32'd4);
        check("to_err_sticky", {31'b0, fetch_err}, 32'd1);
`else
        // No ack: WAIT persists and fetch_err stays 0.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            check("noack_busy", {31'b0, busy}, 32'd1);
            check("noack_req", {31'b0, imem_req}, 32'd1);
        end
        check("noack_err", {31'b0, fetch_err}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_4444;
        tick();
        imem_ack = 1'b0;
        m_pc     = m_pc + 32'd4;
        check("noack_done_pc", pc, m_pc);
        check("noack_done_ir", ir, 32'h3333_4444);
`endif

        // Reset in the middle of WAIT drops the request asynchronously.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0800;
        tick();
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("mid_req_up", {31'b0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        check("mid_rst_pc", pc, RESET_PC);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_ir", ir, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_pc = RESET_PC;
        do_fetch(32'h0800_0010, 1, 1'b0, 0, 32'h0, RESET_PC, RESET_PC + 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
